// File: rtl/iter_shifter.sv
`default_nettype none
// ============================================================================
// Module  : iter_shifter
// Brief   : Multi-cycle iterative shifter (srl/sll/sra/ror) with start/done
//           handshake, shifting up to STEP positions per clock.
// Revision: 1.0 - initial release
// ============================================================================
module iter_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] b
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0]   MD_SRL = 2'b00;
  localparam logic [1:0]   MD_SLL = 2'b01;
  localparam logic [1:0]   MD_SRA = 2'b10;
  localparam logic [1:0]   MD_ROR = 2'b11;
  localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [1:0]       md_q, md_d;
  logic             sign_q, sign_d;

  logic [SHW:0]     rem_ext;
  logic [SHW:0]     k;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  // One-position shift stage; the sra fill comes from the sign latched at
  // capture rather than the current accumulator MSB.
  function automatic logic [WIDTH-1:0] shift1(
    input logic [WIDTH-1:0] x,
    input logic [1:0]       m,
    input logic             s
  );
    case (m)
      MD_SLL:  return {x[WIDTH-2:0], 1'b0};
      MD_SRA:  return {s, x[WIDTH-1:1]};
      MD_ROR:  return {x[0], x[WIDTH-1:1]};
      default: return {1'b0, x[WIDTH-1:1]};
    endcase
  endfunction

  always_comb begin
    rem_ext = {1'b0, rem_q};
    k       = (rem_ext < STEP_W) ? rem_ext : STEP_W;
  end

  // Chain of STEP single-position stages, each enabled while j < k.
  always_comb begin
    shifted = acc_q;
    for (int j = 0; j < STEP; j++) begin
      if (k > (SHW+1)'(j)) begin
        shifted = shift1(shifted, md_q, sign_q);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    md_d    = md_q;
    sign_d  = sign_q;
    b_d     = b_q;
    accept  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    case (state_q)
      ST_SHIFT: begin
        acc_d = shifted;
        rem_d = rem_q - k[SHW-1:0];
        if (rem_d == '0) begin
          b_d     = shifted;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Accepting from DONE overrides the return to IDLE for back-to-back ops.
    if (accept) begin
      acc_d  = a;
      rem_d  = shamt;
      md_d   = mode;
      sign_d = a[WIDTH-1];
      if (shamt == '0) begin
        b_d     = a;
        state_d = ST_DONE;
      end else begin
        state_d = ST_SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      md_q    <= MD_SRL;
      sign_q  <= 1'b0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      md_q    <= md_d;
      sign_q  <= sign_d;
      b_q     <= b_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign b    = b_q;

endmodule
`default_nettype wire

// File: tb/tb_iter_shifter.sv
`default_nettype none
// ============================================================================
// Module  : tb_iter_shifter
// Brief   : Scoreboard bench for iter_shifter, one instance with STEP=1 and
//           one with STEP=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iter_shifter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       start_v;
  logic [1:0][31:0] a_v;
  logic [1:0][4:0]  sh_v;
  logic [1:0][1:0]  md_v;
  logic [1:0]       busy_v;
  logic [1:0]       done_v;
  logic [1:0][31:0] b_v;

  int               n_total;
  int               n_bad;
  int               done_cnt [2];
  logic [31:0]      q0 [$];
  logic [31:0]      q1 [$];

  iter_shifter #(.WIDTH(32), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0]),
    .shamt(sh_v[0]), .mode(md_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .b(b_v[0])
  );

  iter_shifter #(.WIDTH(32), .STEP(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1]),
    .shamt(sh_v[1]), .mode(md_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .b(b_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input int s, input logic [1:0] m);
    case (m)
      2'b00:   return x >> s;
      2'b01:   return x << s;
      2'b10:   return $unsigned($signed(x) >>> s);
      default: return (s == 0) ? x : ((x >> s) | (x << (32 - s)));
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [31:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  // Scoreboard: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (done_v[i]) begin
          done_cnt[i]++;
          if (i == 0) begin
            if (q0.size() == 0) check("unexp_done0", {31'b0, done_v[0]}, 32'd0);
            else                check("sb_b0", b_v[0], q0.pop_front());
          end else begin
            if (q1.size() == 0) check("unexp_done1", {31'b0, done_v[1]}, 32'd0);
            else                check("sb_b1", b_v[1], q1.pop_front());
          end
        end
      end
    end
  end

  // Issue one op on DUT i, optionally poking a stray start mid-shift.
  task automatic run_op(input int i, input logic [31:0] av, input logic [4:0] sv,
                        input logic [1:0] mv, input int poke);
    int          step;
    int          exp_n;
    int          cnt;
    int          cyc;
    logic [31:0] expv;
    step  = (i == 0) ? 1 : 4;
    exp_n = (int'(sv) + step - 1) / step;
    expv  = ref_shift(av, int'(sv), mv);
    cnt   = 0;
    cyc   = 0;
    @(negedge clk);
    start_v[i] = 1'b1; a_v[i] = av; sh_v[i] = sv; md_v[i] = mv;
    push_exp(i, expv);
    @(negedge clk);
    start_v[i] = 1'b0;
    a_v[i] = $urandom; sh_v[i] = 5'($urandom); md_v[i] = 2'($urandom);
    while (!done_v[i] && cyc < 200) begin
      if (busy_v[i]) cnt++;
      start_v[i] = (cyc == poke);
      @(negedge clk);
      start_v[i] = 1'b0;
      cyc++;
    end
    if (cyc >= 200) check("timeout", 32'd0, 32'd1);
    else            check("busy_cycles", 32'(cnt), 32'(exp_n));
    @(negedge clk);
    check("done_pulse", {31'b0, done_v[i]}, 32'd0);
    check("b_hold", b_v[i], expv);
  endtask

  // Two ops with start held through DONE of the first.
  task automatic run_b2b(input int i, input logic [31:0] a1, input logic [4:0] s1,
                         input logic [1:0] m1, input logic [31:0] a2,
                         input logic [4:0] s2, input logic [1:0] m2);
    int cyc;
    int base;
    base = done_cnt[i];
    @(negedge clk);
    start_v[i] = 1'b1; a_v[i] = a1; sh_v[i] = s1; md_v[i] = m1;
    push_exp(i, ref_shift(a1, int'(s1), m1));
    @(negedge clk);
    start_v[i] = 1'b0;
    cyc = 0;
    while (!done_v[i] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    start_v[i] = 1'b1; a_v[i] = a2; sh_v[i] = s2; md_v[i] = m2;
    push_exp(i, ref_shift(a2, int'(s2), m2));
    @(negedge clk);
    start_v[i] = 1'b0;
    check("b2b_accept", {31'b0, busy_v[i]}, 32'd1);
    cyc = 0;
    while (!done_v[i] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 200) check("b2b_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("b2b_done_count", 32'(done_cnt[i] - base), 32'd2);
  endtask

  initial begin
    int base;
    n_total = 0;
    n_bad   = 0;
    done_cnt[0] = 0;
    done_cnt[1] = 0;
    rst_n   = 1'b0;
    start_v = '0;
    a_v     = '0;
    sh_v    = '0;
    md_v    = '0;

    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", {31'b0, busy_v[i]}, 32'd0);
      check("rst_done", {31'b0, done_v[i]}, 32'd0);
      check("rst_b", b_v[i], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'h0000_00F0, 5'd4,  2'b00, -1);
    run_op(0, 32'h8000_0000, 5'd31, 2'b10, -1);
    run_op(0, 32'h0000_0001, 5'd31, 2'b01, -1);
    run_op(0, 32'hDEAD_BEEF, 5'd0,  2'b01, -1);
    run_op(1, 32'hDEAD_BEEF, 5'd0,  2'b01, -1);
    run_op(1, 32'h1234_5678, 5'd6,  2'b00, -1);
    run_op(1, 32'h0000_0001, 5'd1,  2'b11, -1);
    run_op(1, 32'h8765_4321, 5'd31, 2'b10, -1);
    run_op(1, 32'h0F0F_00FF, 5'd13, 2'b11, -1);

    // Stray start during SHIFT must not disturb the op in flight.
    run_op(0, 32'hA5A5_0001, 5'd10, 2'b01, 3);
    run_op(1, 32'hC000_1234, 5'd20, 2'b10, 1);

    for (int n = 0; n < 8; n++) begin
      run_op(0, $urandom, 5'($urandom), 2'($urandom), -1);
      run_op(1, $urandom, 5'($urandom), 2'($urandom), -1);
    end

    run_b2b(0, 32'hF000_000F, 5'd3, 2'b11, 32'h8000_0000, 5'd5, 2'b10);
    run_b2b(1, 32'h0000_FFFF, 5'd8, 2'b01, 32'h1234_5678, 5'd7, 2'b00);

    // Asynchronous reset mid-shift discards the op; start under reset is ignored.
    run_op(0, 32'h0000_0F00, 5'd4, 2'b00, -1);
    base = done_cnt[0];
    @(negedge clk);
    start_v[0] = 1'b1; a_v[0] = 32'hFFFF_FFFF; sh_v[0] = 5'd31; md_v[0] = 2'b00;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy_v[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy_v[0]}, 32'd0);
    check("arst_done", {31'b0, done_v[0]}, 32'd0);
    check("arst_b", b_v[0], 32'd0);
    q0.delete();
    start_v[0] = 1'b1; sh_v[0] = 5'd3;
    @(negedge clk);
    check("rst_start_busy", {31'b0, busy_v[0]}, 32'd0);
    start_v[0] = 1'b0;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt[0] - base), 32'd0);
    check("idle_after_rst", {31'b0, busy_v[0]}, 32'd0);

    run_op(0, 32'h0000_0003, 5'd2, 2'b11, -1);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
